// File: rtl/pdp8i_timing_gen.sv
// PDP-8/I major timing: TS1..TS4 time states of TS_LEN clks each, with TP pulses in the last clk of every state.
// Outputs are registered (one clk after the deciding edge); there is no backpressure, and stop requests take effect only at TP4.
module pdp8i_timing_gen #(
  parameter int TS_LEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_start,
  input  logic        key_stop,
  input  logic        sing_cyc,
  output logic        run,
  output logic [3:0]  ts,
  output logic [3:0]  tp,
  output logic        cyc_done,
  output logic [11:0] cyc_count
);

  localparam int DW = (TS_LEN > 2) ? $clog2(TS_LEN) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TS_LEN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    idx_q, idx_d;
  logic          stop_q, stop_d;
  logic [11:0]   cnt_q, cnt_d;
  logic [3:0]    ts_q, ts_d, tp_q, tp_d;
  logic          ts_end, cyc_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      cnt_q   <= '0;
      ts_q    <= '0;
      tp_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      cnt_q   <= cnt_d;
      ts_q    <= ts_d;
      tp_q    <= tp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    stop_d  = stop_q | key_stop;
    cnt_d   = cnt_q;
    ts_end  = (state_q == RUN) && (div_q == DIV_LAST);
    cyc_end = ts_end && (idx_q == 2'd3);

    case (state_q)
      IDLE: begin
        if (key_start) begin
          state_d = RUN;
          div_d   = '0;
          idx_d   = '0;
        end
      end
      RUN: begin
        div_d = ts_end ? '0 : div_q + DW'(1);
        if (ts_end) idx_d = idx_q + 2'd1;
        // A stop arriving on the TP4 edge itself still ends this cycle.
        if (cyc_end) begin
          cnt_d = cnt_q + 12'd1;
          if (stop_d || sing_cyc) begin
            state_d = IDLE;
            stop_d  = 1'b0;
            idx_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Output registers are loaded from next-state values so that ts/tp are glitch-free flops.
    ts_d = (state_d == RUN) ? (4'b0001 << idx_d) : 4'b0000;
    tp_d = ((state_d == RUN) && (div_d == DIV_LAST)) ? ts_d : 4'b0000;
  end

  assign run       = (state_q == RUN);
  assign ts        = ts_q;
  assign tp        = tp_q;
  assign cyc_done  = tp_q[3];
  assign cyc_count = cnt_q;

endmodule

// File: doc/pdp8i_timing_gen.md
PDP8I_TIMING_GEN -- requirements
Module: pdp8i_timing_gen

Interface
REQ-001 The module SHALL have a single clock and an asynchronous, active-high reset: clock port clk, reset port reset.
REQ-002 Parameter TS_LEN, default 4: number of clk cycles per time state; legal range 2..64.
REQ-003 clk  input  1  system clock; all state changes occur on the rising edge.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 key_start  input  1  start request; sampled each clk edge.
REQ-006 key_stop  input  1  stop request; sampled each clk edge.
REQ-007 sing_cyc  input  1  single-cycle mode level; while high, the processor halts after every memory cycle.
REQ-008 run  output  1  processor running.
REQ-009 ts  output  4  one-hot time states TS1..TS4 (bit 0 = TS1).
REQ-010 tp  output  4  time pulses TP1..TP4 (bit 0 = TP1), fed to downstream NAND gating.
REQ-011 cyc_done  output  1  one-clk pulse marking the end of a memory cycle.
REQ-012 cyc_count  output  12  completed memory cycles since reset, modulo 4096.

Function
REQ-013 The module SHALL be a two-state FSM: IDLE, RUN; a divider div counts 0..TS_LEN-1; a 2-bit time-state index selects TS1..TS4.
REQ-014 IDLE: run=0, ts=0000, tp=0000, div held at 0.
REQ-015 IDLE->RUN on an edge sampling key_start=1: after that edge, run=1, ts=0001, div=0.
REQ-016 In RUN, div SHALL increment every clk; at div=TS_LEN-1 it SHALL wrap to 0 and ts SHALL rotate TS1->TS2->TS3->TS4->TS1.
REQ-017 tp[n] SHALL be high exactly during the last clk of TSn (ts[n]=1 and div=TS_LEN-1), and low otherwise; all outputs SHALL be registered or derived only from registered state, glitch-free.
REQ-018 A memory cycle SHALL be 4*TS_LEN clks; cyc_done SHALL equal tp[3].
REQ-019 cyc_count SHALL increment by 1 on the edge ending each TP4 clk, wrapping 4095->0.
REQ-020 A stop latch SHALL be set by key_stop=1 sampled in any state, and cleared on entry to IDLE.
REQ-021 At the edge ending TP4: if the stop latch is set, the latch is being set on that same edge, or sing_cyc=1, the FSM SHALL go to IDLE (run=0, ts=0000); otherwise it SHALL continue into TS1.
REQ-022 A stop SHALL never truncate a cycle: run SHALL fall only at a TP4 boundary.
REQ-023 key_start while in RUN SHALL be ignored.
REQ-024 key_start and key_stop both 1 on the same edge in IDLE: the FSM SHALL enter RUN, set the stop latch, execute exactly one memory cycle, then return to IDLE.
REQ-025 key_start held high continuously in IDLE with sing_cyc=1: the FSM SHALL re-enter RUN on the edge after returning to IDLE (one idle clk between cycles).

Reset
REQ-026 reset=1 SHALL immediately, without waiting for clk, force IDLE, run=0, ts=0000, tp=0000, cyc_done=0, cyc_count=0, div=0, and clear the stop latch.
REQ-027 reset asserted mid-cycle SHALL abort the cycle; no cyc_done pulse SHALL be produced for it.
REQ-028 After reset deasserts, the FSM SHALL remain in IDLE until key_start is sampled high.

Verification
REQ-029 TS_LEN=4; pulse key_start at edge 0 -> run=1 from edge 0; TS1 clks 0-3, TP1 in clk 3; TP2 clk 7; TP3 clk 11; TP4/cyc_done clk 15; cyc_count=1 after edge 16; run stays 1.
REQ-030 Running; pulse key_stop during TS2 -> current cycle completes; run=0 and ts=0000 after the edge ending TP4; no further tp pulses.
REQ-031 sing_cyc=1, one key_start pulse -> exactly 4 tp pulses, one cyc_done, cyc_count 0->1, then IDLE.
REQ-032 key_start and key_stop high on the same edge in IDLE -> exactly one 16-clk cycle, then IDLE.
REQ-033 Assert reset asynchronously during TS3 -> all outputs 0 before the next clk edge; cyc_count=0; FSM in IDLE after release.
REQ-034 Preload 4095 completed cycles (free-run), then complete one more cycle -> cyc_count wraps to 0 with cyc_done high in the wrapping cycle; TS_LEN=2 run -> 8-clk cycles, each tp exactly one clk wide.
